// File: rtl/damage_controller_pkg.sv
// Shared game definitions: damage FSM encodings, frame-timing defaults and
// the hit-counter width used by the damage controller and its grace timer.
package damage_controller_pkg;

    localparam logic [1:0] ST_ARMED   = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_GRACE   = 2'd2;
    localparam logic [1:0] ST_DEAD    = 2'd3;

    localparam int FRAME_COUNT_W        = 10;
    localparam int DEFAULT_GRACE_FRAMES = 120;
    localparam int DEFAULT_BLINK_FRAMES = 8;

    localparam int                     HIT_COUNT_W   = 8;
    localparam logic [HIT_COUNT_W-1:0] HIT_COUNT_MAX = 8'd255;

    typedef logic [FRAME_COUNT_W-1:0] frame_count_t;

    // Saturating increment: the hit counter sticks at its maximum.
    function automatic logic [HIT_COUNT_W-1:0] sat_inc(input logic [HIT_COUNT_W-1:0] value);
        logic [HIT_COUNT_W-1:0] result;
        if (value == HIT_COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/damage_controller_if.sv
// Signal bundle between the damage controller, the collision logic,
// the lives updater and the sprite renderer.
interface damage_controller_if;
    import damage_controller_pkg::*;

    logic                   frameTick;
    logic                   collision;
    logic                   livesReady;
    logic                   gameOver;
    logic                   loseLife;
    logic                   invulnerable;
    logic                   playerVisible;
    logic [HIT_COUNT_W-1:0] hitCount;

    modport master (
        output frameTick, collision, livesReady, gameOver,
        input  loseLife, invulnerable, playerVisible, hitCount
    );

    modport slave (
        input  frameTick, collision, livesReady, gameOver,
        output loseLife, invulnerable, playerVisible, hitCount
    );

endinterface

// File: rtl/damage_controller_grace_timer.sv
// Frame-counted invulnerability window with sprite blinking. Idles with both
// counters at zero and the sprite visible whenever no window is running.
module damage_controller_grace_timer
    import damage_controller_pkg::*;
#(
    parameter int GRACE_FRAMES = DEFAULT_GRACE_FRAMES,
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic frame_tick,
    output logic expired,
    output logic visible
);

    localparam frame_count_t GRACE_LOAD = FRAME_COUNT_W'(GRACE_FRAMES);
    localparam frame_count_t BLINK_LAST = FRAME_COUNT_W'(BLINK_FRAMES - 1);

    frame_count_t grace_count_r;
    frame_count_t blink_count_r;
    logic         visible_r;

    // Combinational so the controller can leave grace on the final tick's edge.
    assign expired = frame_tick && (grace_count_r == 10'd1);
    assign visible = visible_r;

    // Grace/blink counters and the visibility toggle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grace_count_r <= 10'd0;
            blink_count_r <= 10'd0;
            visible_r     <= 1'b1;
        end else if (clear) begin
            grace_count_r <= 10'd0;
            blink_count_r <= 10'd0;
            visible_r     <= 1'b1;
        end else if (load) begin
            grace_count_r <= GRACE_LOAD;
            blink_count_r <= 10'd0;
            visible_r     <= 1'b1;
        end else if (frame_tick && (grace_count_r != 10'd0)) begin
            if (grace_count_r == 10'd1) begin
                grace_count_r <= 10'd0;
                blink_count_r <= 10'd0;
                visible_r     <= 1'b1;
            end else begin
                grace_count_r <= grace_count_r - 10'd1;
                if (blink_count_r == BLINK_LAST) begin
                    blink_count_r <= 10'd0;
                    visible_r     <= ~visible_r;
                end else begin
                    blink_count_r <= blink_count_r + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/damage_controller.sv
// Turns a level collision into one enable/ready life-loss request per hit,
// then runs an invulnerability window; locks up on game over until reset.
module damage_controller
    import damage_controller_pkg::*;
#(
    parameter int GRACE_FRAMES = DEFAULT_GRACE_FRAMES,
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic                clock,
    input  logic                reset,
    damage_controller_if.slave  dmg
);

    logic [1:0]             state_r;
    logic [1:0]             state_s;
    logic                   lose_life_r;
    logic                   lose_life_s;
    logic                   invulnerable_r;
    logic                   invulnerable_s;
    logic [HIT_COUNT_W-1:0] hit_count_r;
    logic [HIT_COUNT_W-1:0] hit_count_s;
    logic                   load_s;
    logic                   clear_s;
    logic                   expired_s;
    logic                   visible_s;

    damage_controller_grace_timer #(
        .GRACE_FRAMES (GRACE_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_grace_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load_s),
        .clear      (clear_s),
        .frame_tick (dmg.frameTick),
        .expired    (expired_s),
        .visible    (visible_s)
    );

    // Next-state, handshake and hit-count decisions from the sampled inputs.
    always_comb begin
        state_s        = state_r;
        lose_life_s    = lose_life_r;
        invulnerable_s = invulnerable_r;
        hit_count_s    = hit_count_r;
        load_s         = 1'b0;
        clear_s        = 1'b0;
        case (state_r)
            ST_ARMED: begin
                invulnerable_s = 1'b0;
                lose_life_s    = 1'b0;
                if (dmg.gameOver) begin
                    state_s        = ST_DEAD;
                    invulnerable_s = 1'b1;
                    clear_s        = 1'b1;
                end else if (dmg.collision && dmg.livesReady) begin
                    state_s     = ST_REQUEST;
                    lose_life_s = 1'b1;
                    hit_count_s = sat_inc(hit_count_r);
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_REQUEST: begin
                // Enable stays up until ready drops so the updater cannot miss it.
                if (dmg.gameOver) begin
                    state_s        = ST_DEAD;
                    lose_life_s    = 1'b0;
                    invulnerable_s = 1'b1;
                    clear_s        = 1'b1;
                end else if (!dmg.livesReady) begin
                    state_s        = ST_GRACE;
                    lose_life_s    = 1'b0;
                    invulnerable_s = 1'b1;
                    load_s         = 1'b1;
                end else begin
                    lose_life_s = 1'b1;
                end
            end
            ST_GRACE: begin
                lose_life_s = 1'b0;
                if (dmg.gameOver) begin
                    state_s        = ST_DEAD;
                    invulnerable_s = 1'b1;
                    clear_s        = 1'b1;
                end else if (expired_s) begin
                    state_s        = ST_ARMED;
                    invulnerable_s = 1'b0;
                end else begin
                    invulnerable_s = 1'b1;
                end
            end
            ST_DEAD: begin
                lose_life_s    = 1'b0;
                invulnerable_s = 1'b1;
                clear_s        = 1'b1;
            end
            default: begin
                state_s        = ST_ARMED;
                lose_life_s    = 1'b0;
                invulnerable_s = 1'b0;
                clear_s        = 1'b1;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_ARMED;
            lose_life_r    <= 1'b0;
            invulnerable_r <= 1'b0;
            hit_count_r    <= 8'd0;
        end else begin
            state_r        <= state_s;
            lose_life_r    <= lose_life_s;
            invulnerable_r <= invulnerable_s;
            hit_count_r    <= hit_count_s;
        end
    end

    assign dmg.loseLife      = lose_life_r;
    assign dmg.invulnerable  = invulnerable_r;
    assign dmg.playerVisible = visible_s;
    assign dmg.hitCount      = hit_count_r;

endmodule

// File: tb/tb_damage_controller.sv
// Scenario bench for damage_controller with a short grace window and a
// cycle-level lives updater model for the game-over path.
module tb_damage_controller;
    import damage_controller_pkg::*;

    localparam int GRACE = 4;
    localparam int BLINK = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    damage_controller_if dif ();

    damage_controller #(.GRACE_FRAMES(GRACE), .BLINK_FRAMES(BLINK)) dut (
        .clock (clock),
        .reset (reset),
        .dmg   (dif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    // lives updater model state
    logic ready_m;
    logic go_m;
    int   lives_m;
    int   dly_m;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input logic ft, input logic col, input logic rdy, input logic go);
        dif.frameTick  = ft;
        dif.collision  = col;
        dif.livesReady = rdy;
        dif.gameOver   = go;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        step();
        step();
        reset = 1'b1;
    endtask

    // Grace window with no checks, used to return to ARMED.
    task automatic run_grace();
        for (int i = 0; i < GRACE; i++) begin
            dif.frameTick = 1'b1;
            step();
            dif.frameTick = 1'b0;
        end
    endtask

    task automatic model_cycle(input logic ft);
        logic rdy_n;
        logic go_n;
        int   lives_n;
        int   dly_n;
        rdy_n = ready_m; go_n = go_m; lives_n = lives_m; dly_n = dly_m;
        if (dly_m == 1) go_n = 1'b1;
        if (dly_m != 0) dly_n = dly_m - 1;
        if (ready_m && dif.loseLife === 1'b1) begin
            lives_n = lives_m - 1;
            rdy_n   = 1'b0;
            if (lives_n == 0) dly_n = 2;
        end else if (!ready_m && dif.loseLife === 1'b0 && lives_m != 0) begin
            rdy_n = 1'b1;
        end
        dif.frameTick = ft;
        step();
        ready_m = rdy_n; go_m = go_n; lives_m = lives_n; dly_m = dly_n;
        dif.livesReady = rdy_n;
        dif.gameOver   = go_n;
        dif.frameTick  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        n_cmp++; if (dif.loseLife !== 1'b0) begin n_bad++; $display("FAIL reset_lose: got %b want 0", dif.loseLife); end
        n_cmp++; if (dif.invulnerable !== 1'b0) begin n_bad++; $display("FAIL reset_inv: got %b want 0", dif.invulnerable); end
        n_cmp++; if (dif.playerVisible !== 1'b1) begin n_bad++; $display("FAIL reset_vis: got %b want 1", dif.playerVisible); end
        n_cmp++; if (dif.hitCount !== 8'd0) begin n_bad++; $display("FAIL reset_hits: got %0d want 0", dif.hitCount); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
    endtask

    task automatic test_first_hit();
        int e;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(1);
        step();
        n_cmp++; if (dif.loseLife !== 1'b1) begin n_bad++; $display("FAIL hit_lose: got %b want 1", dif.loseLife); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        n_cmp++; if (dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL hit_count: got %0d want %0d", dif.hitCount, e); end
        n_cmp++; if (dif.invulnerable !== 1'b0) begin n_bad++; $display("FAIL hit_inv_early: got %b want 0", dif.invulnerable); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++; if (dif.loseLife !== 1'b0) begin n_bad++; $display("FAIL hit_release: got %b want 0", dif.loseLife); end
        n_cmp++; if (dif.invulnerable !== 1'b1) begin n_bad++; $display("FAIL hit_inv: got %b want 1", dif.invulnerable); end
        dif.livesReady = 1'b1;
    endtask

    task automatic test_grace_blink();
        logic exp_vis [4];
        logic exp_inv [4];
        exp_vis = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_inv = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < GRACE; i++) begin
            dif.frameTick = 1'b1;
            step();
            dif.frameTick = 1'b0;
            n_cmp++; if (dif.playerVisible !== exp_vis[i]) begin n_bad++; $display("FAIL blink_vis tick %0d: got %b want %b", i + 1, dif.playerVisible, exp_vis[i]); end
            n_cmp++; if (dif.invulnerable !== exp_inv[i]) begin n_bad++; $display("FAIL blink_inv tick %0d: got %b want %b", i + 1, dif.invulnerable, exp_inv[i]); end
            step();
            n_cmp++; if (dif.playerVisible !== exp_vis[i]) begin n_bad++; $display("FAIL blink_hold tick %0d: got %b want %b", i + 1, dif.playerVisible, exp_vis[i]); end
        end
    endtask

    task automatic test_collision_through_grace();
        int e;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(1);
        step();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        n_cmp++; if (dif.loseLife !== 1'b1 || dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL thru_first: got lose %b hits %0d want 1/%0d", dif.loseLife, dif.hitCount, e); end
        dif.livesReady = 1'b0;
        step();
        dif.livesReady = 1'b1;
        for (int i = 0; i < GRACE; i++) begin
            dif.frameTick = 1'b1;
            step();
            dif.frameTick = 1'b0;
            n_cmp++; if (dif.loseLife !== 1'b0) begin n_bad++; $display("FAIL thru_grace_lose tick %0d: got %b want 0", i + 1, dif.loseLife); end
            if (i < GRACE - 1) begin
                step();
                n_cmp++; if (dif.loseLife !== 1'b0) begin n_bad++; $display("FAIL thru_grace_idle tick %0d: got %b want 0", i + 1, dif.loseLife); end
            end
        end
        n_cmp++; if (dif.invulnerable !== 1'b0) begin n_bad++; $display("FAIL thru_rearm_inv: got %b want 0", dif.invulnerable); end
        exp_q.push_back(2);
        step();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        n_cmp++; if (dif.loseLife !== 1'b1 || dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL thru_second: got lose %b hits %0d want 1/%0d", dif.loseLife, dif.hitCount, e); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        dif.livesReady = 1'b1;
        run_grace();
        n_cmp++; if (dif.hitCount !== 8'd2) begin n_bad++; $display("FAIL thru_total: got %0d want 2", dif.hitCount); end
    endtask

    task automatic test_hold_ready();
        int e;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(3);
        step();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        n_cmp++; if (dif.loseLife !== 1'b1 || dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL hold_start: got lose %b hits %0d want 1/%0d", dif.loseLife, dif.hitCount, e); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (dif.loseLife !== 1'b1 || dif.hitCount !== 8'd3) begin n_bad++; $display("FAIL hold_cycle %0d: got lose %b hits %0d want 1/3", i, dif.loseLife, dif.hitCount); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++; if (dif.loseLife !== 1'b0 || dif.invulnerable !== 1'b1) begin n_bad++; $display("FAIL hold_grace: got lose %b inv %b want 0/1", dif.loseLife, dif.invulnerable); end
        dif.livesReady = 1'b1;
        run_grace();
        n_cmp++; if (dif.invulnerable !== 1'b0) begin n_bad++; $display("FAIL hold_rearm: got %b want 0", dif.invulnerable); end
    endtask

    task automatic test_game_over();
        int e;
        int waited;
        do_reset();
        ready_m = 1'b1; go_m = 1'b0; lives_m = 3; dly_m = 0;
        for (int h = 1; h <= 3; h++) begin
            dif.collision = 1'b1;
            exp_q.push_back(h);
            waited = 0;
            while (dif.loseLife !== 1'b1 && waited < 20) begin
                model_cycle(1'b0);
                waited++;
            end
            n_cmp++;
            if (dif.loseLife !== 1'b1) begin
                n_bad++; $display("FAIL go_hit %0d: loseLife timeout, got %b want 1", h, dif.loseLife);
            end else begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                if (dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL go_hit %0d: got hits %0d want %0d", h, dif.hitCount, e); end
            end
            dif.collision = 1'b0;
            for (int c = 0; c < 20; c++) model_cycle(c % 2 == 0);
        end
        n_cmp++; if (dif.loseLife !== 1'b0) begin n_bad++; $display("FAIL dead_lose: got %b want 0", dif.loseLife); end
        n_cmp++; if (dif.invulnerable !== 1'b1) begin n_bad++; $display("FAIL dead_inv: got %b want 1", dif.invulnerable); end
        n_cmp++; if (dif.hitCount !== 8'd3) begin n_bad++; $display("FAIL dead_hits: got %0d want 3", dif.hitCount); end
        n_cmp++; if (dif.playerVisible !== 1'b1) begin n_bad++; $display("FAIL dead_vis: got %b want 1", dif.playerVisible); end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            dif.frameTick = (i % 3 == 0);
            step();
            n_cmp++; if (dif.loseLife !== 1'b0 || dif.hitCount !== 8'd3 || dif.invulnerable !== 1'b1) begin n_bad++; $display("FAIL dead_frozen %0d: got lose %b hits %0d inv %b want 0/3/1", i, dif.loseLife, dif.hitCount, dif.invulnerable); end
        end
    endtask

    task automatic test_reset_mid_request();
        int e;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(1);
        step();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        n_cmp++; if (dif.loseLife !== 1'b1 || dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL mid_req: got lose %b hits %0d want 1/%0d", dif.loseLife, dif.hitCount, e); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (dif.loseLife !== 1'b0) begin n_bad++; $display("FAIL mid_async_lose: got %b want 0", dif.loseLife); end
        n_cmp++; if (dif.hitCount !== 8'd0 || dif.invulnerable !== 1'b0 || dif.playerVisible !== 1'b1) begin n_bad++; $display("FAIL mid_async_outs: got hits %0d inv %b vis %b want 0/0/1", dif.hitCount, dif.invulnerable, dif.playerVisible); end
        step();
        reset = 1'b1;
        exp_q.push_back(1);
        step();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        n_cmp++; if (dif.loseLife !== 1'b1 || dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL mid_after: got lose %b hits %0d want 1/%0d", dif.loseLife, dif.hitCount, e); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++; if (dif.invulnerable !== 1'b1) begin n_bad++; $display("FAIL mid_grace: got %b want 1", dif.invulnerable); end
        dif.livesReady = 1'b1;
        run_grace();
    endtask

    task automatic test_saturation();
        int e;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            exp_q.push_back((k > 255) ? 255 : k);
            step();
            n_cmp++;
            if (dif.loseLife !== 1'b1) begin
                n_bad++; $display("FAIL sat_lose hit %0d: got %b want 1", k, dif.loseLife);
                exp_q.delete();
            end else begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                if (dif.hitCount !== 8'(e)) begin n_bad++; $display("FAIL sat_count hit %0d: got %0d want %0d", k, dif.hitCount, e); end
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            step();
            dif.livesReady = 1'b1;
            run_grace();
        end
        n_cmp++; if (dif.hitCount !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", dif.hitCount); end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        ready_m = 1'b1; go_m = 1'b0; lives_m = 3; dly_m = 0;
        test_reset();
        test_first_hit();
        test_grace_blink();
        test_collision_through_grace();
        test_hold_ready();
        test_game_over();
        test_reset_mid_request();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
